// File: rtl/cpu_decode_pkg.sv
// cpu_decode_pkg: shared CPU records, ALU operation enum, memory widths and the
// RV32IM/Zicsr/F instruction classifier used by the decode stage.
package cpu_decode_pkg;
    localparam int TAG_W = 8;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [6:0] OP_FMADD  = 7'b1000011;
    localparam logic [6:0] OP_FMSUB  = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB = 7'b1001011;
    localparam logic [6:0] OP_FNMADD = 7'b1001111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
    } alu_operation_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      pc;
        logic [31:0]      instruction;
        logic [4:0]       inst_rs1;
        logic [4:0]       inst_rs2;
        logic [4:0]       inst_rs3;
        logic [4:0]       inst_rd;
    } fetch_data_t;

    typedef struct packed {
        alu_operation_t alu_operation;
        logic           arithmetic;
        logic           shift;
        logic           compare;
        logic           jump;
        logic           jump_conditional;
        logic           memory_read;
        logic           memory_write;
        logic [1:0]     memory_width;
        logic           memory_signed;
        logic           complex;
        logic           csr;
        logic           fpu;
        logic           illegal;
    } decode_ctrl_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      pc;
        logic [31:0]      instruction;
        logic [4:0]       rd;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [31:0]      rs3;
        logic [31:0]      immediate;
        decode_ctrl_t     ctrl;
    } decode_data_t;

    function automatic alu_operation_t alu_op(input logic [2:0] f3, input logic alt);
        return f3 == 3'd0 ? (alt ? ALU_SUB : ALU_ADD) : f3 == 3'd1 ? ALU_SLL :
               f3 == 3'd2 ? ALU_LT : f3 == 3'd3 ? ALU_LTU : f3 == 3'd4 ? ALU_XOR :
               f3 == 3'd5 ? (alt ? ALU_SRA : ALU_SRL) : f3 == 3'd6 ? ALU_OR : ALU_AND;
    endfunction

    function automatic alu_operation_t branch_op(input logic [2:0] f3);
        return f3 == 3'd0 ? ALU_EQ : f3 == 3'd1 ? ALU_NE : f3 == 3'd4 ? ALU_LT :
               f3 == 3'd5 ? ALU_GE : f3 == 3'd6 ? ALU_LTU : ALU_GEU;
    endfunction

    function automatic logic [31:0] select_operand(input logic [4:0] idx, input logic [31:0] rf,
                                                   input logic wb_valid, input logic [4:0] wb_rd,
                                                   input logic [31:0] wb_data);
        return idx == 5'd0 ? 32'd0 : (wb_valid && wb_rd == idx) ? wb_data : rf;
    endfunction

    function automatic decode_ctrl_t decode_instruction(input logic [31:0] inst, input logic fpu_en);
        decode_ctrl_t c;
        logic [2:0]   f3;
        logic [6:0]   f7;
        logic         ok;
        f3 = inst[14:12];
        f7 = inst[31:25];
        c  = '0;
        ok = 1'b0;
        case (inst[6:0])
            OP_LUI, OP_AUIPC: begin ok = 1'b1; c.arithmetic = 1'b1; end
            OP_JAL:           begin ok = 1'b1; c.jump = 1'b1; end
            OP_JALR:          begin ok = f3 == 3'd0; c.jump = 1'b1; end
            OP_BRANCH: begin
                ok = f3[2:1] != 2'b01;
                c.jump_conditional = 1'b1;
                c.alu_operation = branch_op(f3);
            end
            OP_LOAD: begin
                ok = f3 != 3'd3 && f3 < 3'd6;
                c.memory_read = 1'b1;
                c.memory_width = f3[1:0];
                c.memory_signed = !f3[2];
            end
            OP_STORE: begin
                ok = f3 < 3'd3;
                c.memory_write = 1'b1;
                c.memory_width = f3[1:0];
            end
            OP_IMM, OP_REG: begin
                // inst[5] separates register-register from register-immediate forms
                c.complex = inst[5] && f7 == 7'd1;
                ok = (!inst[5] && f3 != 3'd1 && f3 != 3'd5) || c.complex || f7 == 7'd0 ||
                     (f7 == 7'h20 && (f3 == 3'd5 || (inst[5] && f3 == 3'd0)));
                if (!c.complex) begin
                    c.alu_operation = alu_op(f3, f7[5] && (f3 == 3'd5 || inst[5]));
                    c.shift = f3[1:0] == 2'b01;
                    c.compare = f3[2:1] == 2'b01;
                    c.arithmetic = !c.shift && !c.compare;
                end
            end
            OP_FENCE:  ok = 1'b1;
            OP_SYSTEM: begin ok = f3[1:0] != 2'b00; c.csr = 1'b1; end
            OP_FLW, OP_FSW: begin ok = fpu_en && f3 == 3'd2; c.fpu = 1'b1; end
            OP_FP, OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin ok = fpu_en; c.fpu = 1'b1; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            c = '0;
            c.illegal = 1'b1;
        end
        return c;
    endfunction
endpackage

// File: rtl/cpu_decode_immediate.sv
// cpu_decode_immediate: selects the instruction format from the opcode and
// assembles the 32-bit immediate.
module cpu_decode_immediate
    import cpu_decode_pkg::*;
(
    input  logic [31:0] i_instruction,
    output logic [31:0] o_immediate
);
    logic [6:0]  w_op;
    logic [31:0] w_i, w_s, w_b, w_u, w_j, w_z;

    assign w_op = i_instruction[6:0];
    assign w_i  = {{20{i_instruction[31]}}, i_instruction[31:20]};
    assign w_s  = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
    assign w_b  = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                   i_instruction[30:25], i_instruction[11:8], 1'b0};
    assign w_u  = {i_instruction[31:12], 12'b0};
    assign w_j  = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                   i_instruction[20], i_instruction[30:21], 1'b0};
    assign w_z  = {27'b0, i_instruction[19:15]};

    // CSR register forms use the I layout; the immediate forms carry a 5-bit zero-extended value
    assign o_immediate =
        (w_op == OP_LOAD || w_op == OP_JALR || w_op == OP_IMM || w_op == OP_FLW ||
         (w_op == OP_SYSTEM && !i_instruction[14])) ? w_i :
        (w_op == OP_SYSTEM)                         ? w_z :
        (w_op == OP_STORE || w_op == OP_FSW)        ? w_s :
        (w_op == OP_BRANCH)                         ? w_b :
        (w_op == OP_LUI || w_op == OP_AUIPC)        ? w_u :
        (w_op == OP_JAL)                            ? w_j : 32'd0;
endmodule

// File: rtl/cpu_decode.sv
// cpu_decode: second pipeline stage; captures a fetch record on tag change and
// registers operands, immediate and operation class for execute.
module cpu_decode
    import cpu_decode_pkg::*;
#(
    parameter bit ENABLE_FPU = 1'b0
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  fetch_data_t  i_data,
    output logic         o_busy,
    input  logic [31:0]  i_rs1,
    input  logic [31:0]  i_rs2,
    input  logic [31:0]  i_rs3,
    input  logic         i_wb_valid,
    input  logic [4:0]   i_wb_rd,
    input  logic [31:0]  i_wb_rdata,
    input  logic         i_busy,
    output decode_data_t o_data
);
    logic [TAG_W-1:0] r_last_tag;
    logic             w_capture;
    decode_ctrl_t     w_ctrl;
    logic [31:0]      w_immediate;

    assign o_busy    = i_busy;
    assign w_capture = i_data.tag != r_last_tag && !i_busy;
    assign w_ctrl    = decode_instruction(i_data.instruction, ENABLE_FPU);

    cpu_decode_immediate u_immediate (
        .i_instruction (i_data.instruction),
        .o_immediate   (w_immediate)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last_tag <= '0;
            o_data     <= '0;
        end else if (w_capture) begin
            r_last_tag         <= i_data.tag;
            o_data.tag         <= o_data.tag + TAG_W'(1);
            o_data.pc          <= i_data.pc;
            o_data.instruction <= i_data.instruction;
            o_data.rd          <= i_data.inst_rd;
            // Illegal encodings forward only pc/instruction so execute can trap cleanly
            o_data.rs1         <= w_ctrl.illegal ? '0 : select_operand(i_data.inst_rs1, i_rs1, i_wb_valid, i_wb_rd, i_wb_rdata);
            o_data.rs2         <= w_ctrl.illegal ? '0 : select_operand(i_data.inst_rs2, i_rs2, i_wb_valid, i_wb_rd, i_wb_rdata);
            o_data.rs3         <= w_ctrl.illegal ? '0 : select_operand(i_data.inst_rs3, i_rs3, i_wb_valid, i_wb_rd, i_wb_rdata);
            o_data.immediate   <= w_ctrl.illegal ? '0 : w_immediate;
            o_data.ctrl        <= w_ctrl;
        end
    end
endmodule

// File: tb/tb_cpu_decode.sv
// tb_cpu_decode: randomized self-checking bench; instructions are built by an
// encoder that knows the intended immediate and class, then compared to o_data.
module tb_cpu_decode;
    import cpu_decode_pkg::*;

    logic         i_clock = 1'b0;
    logic         i_reset = 1'b1;
    fetch_data_t  i_data = '0;
    logic         o_busy;
    logic [31:0]  i_rs1 = '0, i_rs2 = '0, i_rs3 = '0, i_wb_rdata = '0;
    logic         i_wb_valid = 1'b0;
    logic [4:0]   i_wb_rd = '0;
    logic         i_busy = 1'b0;
    decode_data_t o_data;

    int           errors = 0;
    int           checks = 0;
    logic [7:0]   f_tag = '0;
    logic [7:0]   exp_tag = '0;
    decode_data_t exp_rec;

    cpu_decode #(.ENABLE_FPU(1'b0)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_data     (i_data),
        .o_busy     (o_busy),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .i_rs3      (i_rs3),
        .i_wb_valid (i_wb_valid),
        .i_wb_rd    (i_wb_rd),
        .i_wb_rdata (i_wb_rdata),
        .i_busy     (i_busy),
        .o_data     (o_data)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (i_wb_valid && i_wb_rd == idx) return i_wb_rdata;
        return rf;
    endfunction

    // Encode an instruction of a given kind with random fields; report its intended meaning.
    task automatic gen(input int kind, output logic [31:0] inst, output decode_ctrl_t c, output logic [31:0] imm);
        logic [4:0]  rd, rs1, rs2, sh;
        logic [11:0] v12;
        logic [12:0] v13;
        logic [20:0] v21;
        logic [19:0] v20;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); sh = 5'($urandom);
        v12 = 12'($urandom); v13 = {12'($urandom), 1'b0}; v21 = {20'($urandom), 1'b0}; v20 = 20'($urandom);
        c = '0; imm = '0; inst = '0;
        case (kind)
            0: begin inst = {v12, rs1, 3'b000, rd, 7'h13}; imm = {{20{v12[11]}}, v12}; c.arithmetic = 1'b1; end
            1: begin inst = {v12, rs1, 3'b011, rd, 7'h13}; imm = {{20{v12[11]}}, v12}; c.compare = 1'b1; c.alu_operation = ALU_LTU; end
            2: begin inst = {7'h20, sh, rs1, 3'b101, rd, 7'h13}; imm = {20'd0, 7'h20, sh}; c.shift = 1'b1; c.alu_operation = ALU_SRA; end
            3: begin inst = {7'h20, rs2, rs1, 3'b000, rd, 7'h33}; c.arithmetic = 1'b1; c.alu_operation = ALU_SUB; end
            4: begin inst = {7'h01, rs2, rs1, 3'b000, rd, 7'h33}; c.complex = 1'b1; end
            5: begin inst = {v12, rs1, 3'b001, rd, 7'h03}; imm = {{20{v12[11]}}, v12}; c.memory_read = 1'b1; c.memory_width = MEM_HALF; c.memory_signed = 1'b1; end
            6: begin inst = {v12, rs1, 3'b100, rd, 7'h03}; imm = {{20{v12[11]}}, v12}; c.memory_read = 1'b1; c.memory_width = MEM_BYTE; end
            7: begin inst = {v12[11:5], rs2, rs1, 3'b010, v12[4:0], 7'h23}; imm = {{20{v12[11]}}, v12}; c.memory_write = 1'b1; c.memory_width = MEM_WORD; end
            8: begin inst = {v13[12], v13[10:5], rs2, rs1, 3'b001, v13[4:1], v13[11], 7'h63}; imm = {{19{v13[12]}}, v13}; c.jump_conditional = 1'b1; c.alu_operation = ALU_NE; end
            9: begin inst = {v21[20], v21[10:1], v21[11], v21[19:12], rd, 7'h6f}; imm = {{11{v21[20]}}, v21}; c.jump = 1'b1; end
            10: begin inst = {v20, rd, 7'h37}; imm = {v20, 12'd0}; c.arithmetic = 1'b1; end
            11: begin inst = {v12, sh, 3'b101, rd, 7'h73}; imm = {27'd0, sh}; c.csr = 1'b1; end
            12: begin inst = {7'h00, rs2, rs1, 3'b000, rd, 7'h53}; c.illegal = 1'b1; end
            default: begin inst = 32'd0; c.illegal = 1'b1; end
        endcase
    endtask

    // Present a new fetch record and compute the record execute should see after capture.
    task automatic present(input logic [31:0] inst, input decode_ctrl_t c, input logic [31:0] imm, input logic [31:0] pc);
        f_tag++;
        i_data.tag = f_tag;
        i_data.pc = pc;
        i_data.instruction = inst;
        i_data.inst_rs1 = inst[19:15];
        i_data.inst_rs2 = inst[24:20];
        i_data.inst_rs3 = inst[31:27];
        i_data.inst_rd = inst[11:7];
        exp_tag++;
        exp_rec.tag = exp_tag;
        exp_rec.pc = pc;
        exp_rec.instruction = inst;
        exp_rec.rd = inst[11:7];
        exp_rec.rs1 = c.illegal ? 32'd0 : operand(inst[19:15], i_rs1);
        exp_rec.rs2 = c.illegal ? 32'd0 : operand(inst[24:20], i_rs2);
        exp_rec.rs3 = c.illegal ? 32'd0 : operand(inst[31:27], i_rs3);
        exp_rec.immediate = c.illegal ? 32'd0 : imm;
        exp_rec.ctrl = c;
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        i_busy = 1'b1;
        repeat (2) @(negedge i_clock);
        checks++;
        if (o_data !== '0) begin errors++; $display("FAIL reset_odata: got %h want 0", o_data); end
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_hi: got %b want 1", o_busy); end
        i_busy = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_lo: got %b want 0", o_busy); end
        @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);
        checks++;
        if (o_data !== '0) begin errors++; $display("FAIL reset_no_capture: got %h want 0", o_data); end
    endtask

    task automatic test_addi;
        decode_ctrl_t c;
        c = '0;
        c.arithmetic = 1'b1;
        i_rs1 = 32'd10;
        i_wb_valid = 1'b0;
        present(32'hFFD08293, c, 32'hFFFFFFFD, 32'h0000_1000);
        @(negedge i_clock);
        checks++;
        if (o_data.tag !== 8'd1) begin errors++; $display("FAIL addi_tag: got %0d want 1", o_data.tag); end
        checks++;
        if (o_data.rs1 !== 32'd10) begin errors++; $display("FAIL addi_rs1: got %h want a", o_data.rs1); end
        checks++;
        if (o_data.immediate !== 32'hFFFFFFFD) begin errors++; $display("FAIL addi_imm: got %h want fffffffd", o_data.immediate); end
        checks++;
        if (o_data.ctrl.arithmetic !== 1'b1 || o_data.rd !== 5'd5) begin errors++; $display("FAIL addi_flags: got arith=%b rd=%0d want 1/5", o_data.ctrl.arithmetic, o_data.rd); end
        checks++;
        if (o_data !== exp_rec) begin errors++; $display("FAIL addi_record: got %h want %h", o_data, exp_rec); end
    endtask

    task automatic test_busy;
        decode_ctrl_t c;
        decode_data_t snap;
        c = '0;
        c.arithmetic = 1'b1;
        i_busy = 1'b1;
        i_rs1 = 32'd77;
        present(32'hFFD08293, c, 32'hFFFFFFFD, 32'h0000_1004);
        snap = o_data;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clock);
            checks++;
            if (o_data !== snap || o_busy !== 1'b1) begin errors++; $display("FAIL busy_hold%0d: got %h busy=%b want %h", i, o_data, o_busy, snap); end
        end
        i_busy = 1'b0;
        @(negedge i_clock);
        checks++;
        if (o_data !== exp_rec) begin errors++; $display("FAIL busy_release: got %h want %h", o_data, exp_rec); end
        @(negedge i_clock);
        checks++;
        if (o_data.tag !== exp_tag) begin errors++; $display("FAIL busy_single_inc: got %0d want %0d", o_data.tag, exp_tag); end
    endtask

    task automatic test_bypass;
        decode_ctrl_t c;
        c = '0;
        c.arithmetic = 1'b1;
        i_rs1 = 32'h55; i_rs2 = 32'h0;
        i_wb_valid = 1'b1; i_wb_rd = 5'd2; i_wb_rdata = 32'h1234;
        present(32'h002081B3, c, 32'd0, 32'h0000_2000);
        @(negedge i_clock);
        checks++;
        if (o_data.rs2 !== 32'h1234 || o_data.rs1 !== 32'h55) begin errors++; $display("FAIL bypass_rs2: got rs1=%h rs2=%h want 55/1234", o_data.rs1, o_data.rs2); end
        i_wb_rdata = 32'hBEEF;
        @(negedge i_clock);
        checks++;
        if (o_data.rs2 !== 32'h1234) begin errors++; $display("FAIL bypass_late_wb: got %h want 1234", o_data.rs2); end
        i_rs1 = 32'hDEAD; i_wb_rd = 5'd0; i_wb_rdata = 32'h9999;
        present(32'h002001B3, c, 32'd0, 32'h0000_2004);
        @(negedge i_clock);
        checks++;
        if (o_data.rs1 !== 32'd0) begin errors++; $display("FAIL bypass_x0: got %h want 0", o_data.rs1); end
        i_wb_valid = 1'b0;
    endtask

    task automatic test_branch_jump;
        decode_ctrl_t c;
        c = '0;
        c.jump_conditional = 1'b1;
        c.alu_operation = ALU_EQ;
        present(32'hFE000CE3, c, 32'hFFFFFFF8, 32'h0000_3000);
        @(negedge i_clock);
        checks++;
        if (o_data.immediate !== 32'hFFFFFFF8 || o_data.ctrl.jump_conditional !== 1'b1) begin errors++; $display("FAIL beq: got imm=%h jc=%b want fffffff8/1", o_data.immediate, o_data.ctrl.jump_conditional); end
        c = '0;
        c.jump = 1'b1;
        present(32'h001000EF, c, 32'h00000800, 32'h0000_3004);
        @(negedge i_clock);
        checks++;
        if (o_data.immediate !== 32'h00000800 || o_data.ctrl.jump !== 1'b1) begin errors++; $display("FAIL jal: got imm=%h jump=%b want 800/1", o_data.immediate, o_data.ctrl.jump); end
        checks++;
        if (o_data !== exp_rec) begin errors++; $display("FAIL jal_record: got %h want %h", o_data, exp_rec); end
    endtask

    task automatic test_illegal;
        decode_ctrl_t c;
        c = '0;
        c.illegal = 1'b1;
        i_rs1 = 32'hCAFE; i_rs2 = 32'hF00D;
        present(32'h00000000, c, 32'd0, 32'h1234_5678);
        @(negedge i_clock);
        checks++;
        if (o_data.ctrl !== c || o_data.pc !== 32'h1234_5678) begin errors++; $display("FAIL illegal_zero: got ctrl=%h pc=%h want %h/12345678", o_data.ctrl, o_data.pc, c); end
        present(32'h00208053, c, 32'd0, 32'h1234_567C);
        @(negedge i_clock);
        checks++;
        if (o_data !== exp_rec) begin errors++; $display("FAIL illegal_fadd: got %h want %h", o_data, exp_rec); end
    endtask

    task automatic test_random;
        logic [31:0]  inst, imm;
        decode_ctrl_t c;
        for (int i = 0; i < 80; i++) begin
            gen(int'($urandom_range(0, 13)), inst, c, imm);
            i_rs1 = $urandom; i_rs2 = $urandom; i_rs3 = $urandom;
            i_wb_valid = 1'($urandom); i_wb_rdata = $urandom;
            i_wb_rd = $urandom_range(0, 1) ? inst[19:15] : 5'($urandom);
            present(inst, c, imm, $urandom);
            @(negedge i_clock);
            checks++;
            if (o_data !== exp_rec) begin errors++; $display("FAIL random%0d inst=%h: got %h want %h", i, inst, o_data, exp_rec); end
        end
        i_wb_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0]  inst, imm;
        decode_ctrl_t c;
        logic [7:0]   prev;
        int           captures;
        captures = 0;
        prev = o_data.tag;
        for (int i = 0; i < 260; i++) begin
            gen(int'($urandom_range(0, 13)), inst, c, imm);
            i_rs1 = $urandom; i_rs2 = $urandom; i_rs3 = $urandom;
            present(inst, c, imm, 32'h8000_0000 + 32'(i * 4));
            @(negedge i_clock);
            if (o_data.tag != prev) captures++;
            prev = o_data.tag;
            checks++;
            if (o_data !== exp_rec) begin errors++; $display("FAIL b2b%0d: got %h want %h", i, o_data, exp_rec); end
        end
        checks++;
        if (captures != 260) begin errors++; $display("FAIL b2b_count: got %0d want 260", captures); end
    endtask

    task automatic test_reset_midstream;
        logic [31:0]  inst, imm;
        decode_ctrl_t c;
        gen(0, inst, c, imm);
        present(inst, c, imm, 32'h4000);
        i_reset = 1'b1;
        @(negedge i_clock);
        checks++;
        if (o_data !== '0) begin errors++; $display("FAIL midreset_clear: got %h want 0", o_data); end
        f_tag = '0; exp_tag = '0;
        i_data.tag = '0;
        i_reset = 1'b0;
        @(negedge i_clock);
        checks++;
        if (o_data !== '0) begin errors++; $display("FAIL midreset_no_capture: got %h want 0", o_data); end
        present(inst, c, imm, 32'h4004);
        @(negedge i_clock);
        checks++;
        if (o_data !== exp_rec) begin errors++; $display("FAIL midreset_resume: got %h want %h", o_data, exp_rec); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_busy();
        test_bypass();
        test_branch_jump();
        test_illegal();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
